// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding and default timing.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_HOLD = 2'd1,
        STATE_GAP  = 2'd2
    } state_t;

    localparam int DEFAULT_HOLD_CYCLES = 4;
    localparam int DEFAULT_GAP_CYCLES  = 2;

endpackage

// File: rtl/pulse_stretcher_cycle_counter.sv
// Loadable down-counter that times the HOLD and GAP phases of the pulse stretcher.
module pulse_stretcher_cycle_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // A load takes priority over a decrement issued in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-width levels separated by a low gap,
// queueing events that arrive while busy in a saturating pending counter.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES,
    parameter int PEND_W      = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_in,
    input  logic              ovf_clr,
    output logic              l_out,
    output logic              busy,
    output logic [PEND_W-1:0] pend,
    output logic              ovf
);

    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_t            state_d;
    state_t            state_q;
    logic [PEND_W-1:0] pend_d;
    logic [PEND_W-1:0] pend_q;
    logic              ovf_d;
    logic              ovf_q;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_en;
    logic              cnt_zero;
    logic              inc_req;
    logic              ovf_set;

    pulse_stretcher_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        ovf_d        = ovf_q;
        cnt_load     = 1'b0;
        cnt_load_val = HOLD_LOAD;
        cnt_en       = 1'b0;
        inc_req      = 1'b0;
        ovf_set      = 1'b0;

        case (state_q)
            STATE_IDLE: begin
                if (p_in) begin
                    state_d      = STATE_HOLD;
                    cnt_load     = 1'b1;
                    cnt_load_val = HOLD_LOAD;
                end
            end
            STATE_HOLD: begin
                inc_req = p_in;
                if (cnt_zero) begin
                    state_d      = STATE_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_LOAD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            STATE_GAP: begin
                if (cnt_zero) begin
                    // Final gap cycle: a queued or fresh event restarts HOLD directly.
                    // A fresh event with something queued cancels that entry's dequeue.
                    if ((pend_q != '0) || p_in) begin
                        state_d      = STATE_HOLD;
                        cnt_load     = 1'b1;
                        cnt_load_val = HOLD_LOAD;
                    end else begin
                        state_d = STATE_IDLE;
                    end
                    if ((pend_q != '0) && !p_in) begin
                        pend_d = pend_q - PEND_W'(1);
                    end
                end else begin
                    cnt_en  = 1'b1;
                    inc_req = p_in;
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase

        if (inc_req) begin
            if (pend_q == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end

        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= STATE_IDLE;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign l_out = (state_q == STATE_HOLD);
    assign busy  = (state_q != STATE_IDLE);
    assign pend  = pend_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: a schedule-based model predicts each cycle's outputs.
module tb_pulse_stretcher;

    localparam int HOLD   = 4;
    localparam int GAP    = 2;
    localparam int PEND_W = 2;
    localparam int PMAX   = (1 << PEND_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              p_in;
    logic              ovf_clr;
    logic              l_out;
    logic              busy;
    logic [PEND_W-1:0] pend;
    logic              ovf;

    always #5 clk = ~clk;

    pulse_stretcher #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .PEND_W      (PEND_W),
        .CNT_W       (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .p_in    (p_in),
        .ovf_clr (ovf_clr),
        .l_out   (l_out),
        .busy    (busy),
        .pend    (pend),
        .ovf     (ovf)
    );

    typedef struct {
        int   cyc;
        logic l;
        logic b;
        int   p;
        logic o;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: each accepted event is an (event cycle, start cycle) pair.
    int   ev_e[$];
    int   ev_s[$];
    int   last_s = 0;
    bit   have_last = 0;
    bit   m_ovf = 0;
    int   cyc = 0;

    function automatic int pend_at(input int t);
        int n = 0;
        for (int i = 0; i < ev_s.size(); i++)
            if (ev_e[i] < t && t < ev_s[i]) n++;
        return n;
    endfunction

    function automatic bit in_window(input int t, input int len);
        for (int i = 0; i < ev_s.size(); i++)
            if (ev_s[i] <= t && t < ev_s[i] + len) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_cycle(input bit p, input bit r, input bit c, input int t);
        exp_t e;
        int   s;
        int   n;
        bit   drop;
        drop = 1'b0;
        if (!r) begin
            ev_e.delete();
            ev_s.delete();
            have_last = 1'b0;
            m_ovf = 1'b0;
        end else begin
            while (ev_s.size() > 0 && ev_s[0] + HOLD + GAP < t) begin
                void'(ev_s.pop_front());
                void'(ev_e.pop_front());
            end
            if (p) begin
                s = t + 1;
                if (have_last && last_s + HOLD + GAP > s) s = last_s + HOLD + GAP;
                n = pend_at(t + 1) + ((s > t + 1) ? 1 : 0);
                if (n > PMAX) begin
                    drop = 1'b1;
                end else begin
                    ev_e.push_back(t);
                    ev_s.push_back(s);
                    last_s = s;
                    have_last = 1'b1;
                end
            end
            if (drop) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
        end
        e.cyc = t + 1;
        e.l   = in_window(t + 1, HOLD);
        e.b   = in_window(t + 1, HOLD + GAP);
        e.p   = pend_at(t + 1);
        e.o   = m_ovf;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit p, input bit r, input bit c);
        @(negedge clk);
        p_in    = p;
        rst     = r;
        ovf_clr = c;
        model_cycle(p, r, c, cyc);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, c, got, want);
        end
    endtask

    exp_t mon_e;
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("l_out", mon_e.cyc, {31'd0, l_out}, {31'd0, mon_e.l});
            chk("busy",  mon_e.cyc, {31'd0, busy},  {31'd0, mon_e.b});
            chk("pend",  mon_e.cyc, {{(32-PEND_W){1'b0}}, pend}, mon_e.p);
            chk("ovf",   mon_e.cyc, {31'd0, ovf},   {31'd0, mon_e.o});
        end
    end

    initial begin
        rst = 1'b0;
        p_in = 1'b0;
        ovf_clr = 1'b0;

        // Reset held with p_in asserted, then release.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(8);

        // Single event.
        step(1'b1, 1'b1, 1'b0);
        idle(10);

        // Two events, second one queued.
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(14);

        // Fill the pending counter, overflow, then clear ovf.
        repeat (5) step(1'b1, 1'b1, 1'b0);
        idle(30);
        step(1'b0, 1'b1, 1'b1);
        idle(3);

        // Event on the final gap cycle with nothing pending.
        step(1'b1, 1'b1, 1'b0);
        idle(5);
        step(1'b1, 1'b1, 1'b0);
        idle(10);

        // Reset in the middle of a pulse, then a fresh event.
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(8);

        // Overflow and ovf_clr in the same cycle: set wins.
        repeat (4) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        idle(30);

        // Randomized traffic.
        repeat (3000) begin
            step($urandom_range(0, 9) < 3,
                 $urandom_range(0, 99) != 0,
                 $urandom_range(0, 19) == 0);
        end
        idle(3);

        @(posedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
